// File: rtl/pipe_pkg.sv
// Types and constants shared by the pipeline hazard/forwarding logic.
package pipe_pkg;

  // Tags store rd at this fixed width so one struct serves every REG_AW up to it.
  localparam int unsigned TagRdW = 16;

  localparam int unsigned FWD_REGFILE = 0;

  typedef struct packed {
    logic              valid;
    logic [TagRdW-1:0] rd;
    logic              wreg;
    logic              load;
  } pipe_tag_t;

endpackage

// File: rtl/hazard_match.sv
// Matches one source operand against the in-flight destination tags; youngest stage wins.
module hazard_match
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned ZERO_REG   = 0,
  parameter int unsigned SW         = $clog2(DEPTH + 1)
) (
  input  logic [REG_AW-1:0]     rs,
  input  logic                  rs_rd,
  input  pipe_tag_t [DEPTH:1]   tags,
  output logic                  hit,
  output logic [SW-1:0]         sel,
  output logic                  load_hazard
);

  logic [TagRdW-1:0] rs_ext;
  logic              rs_ok;

  assign rs_ext = TagRdW'(rs);
  assign rs_ok  = rs_rd && !((ZERO_REG != 0) && (rs == '0));

  // Scan oldest to youngest so the lowest matching stage is the last one written.
  always_comb begin
    hit         = 1'b0;
    sel         = SW'(FWD_REGFILE);
    load_hazard = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (rs_ok && tags[k].valid && tags[k].wreg && (tags[k].rd == rs_ext)) begin
        hit         = 1'b1;
        sel         = SW'(k);
        load_hazard = tags[k].load && (k < LOAD_STAGE);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding unit: owns the in-flight destination tag pipeline and derives
// forwarding selects, load-use stalls, memory freezes, flush bubbles and a stall counter.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned ZERO_REG   = 0,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned SW        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_rd,
  input  logic              id_rs2_rd,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wreg,
  input  logic              id_m2reg,
  input  logic              flush,
  input  logic              mem_ready,
  output logic [SW-1:0]     fwd_a_sel,
  output logic [SW-1:0]     fwd_b_sel,
  output logic              hold_front,
  output logic              bubble_exe,
  output logic              freeze_back,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_tag_t [DEPTH:1] tag_q, tag_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic          hit_a, hit_b;
  logic [SW-1:0] sel_a, sel_b;
  logic          lh_a, lh_b;
  logic          hazard;

  hazard_match #(
    .REG_AW    (REG_AW),
    .DEPTH     (DEPTH),
    .LOAD_STAGE(LOAD_STAGE),
    .ZERO_REG  (ZERO_REG),
    .SW        (SW)
  ) u_match_a (
    .rs         (id_rs1),
    .rs_rd      (id_rs1_rd),
    .tags       (tag_q),
    .hit        (hit_a),
    .sel        (sel_a),
    .load_hazard(lh_a)
  );

  hazard_match #(
    .REG_AW    (REG_AW),
    .DEPTH     (DEPTH),
    .LOAD_STAGE(LOAD_STAGE),
    .ZERO_REG  (ZERO_REG),
    .SW        (SW)
  ) u_match_b (
    .rs         (id_rs2),
    .rs_rd      (id_rs2_rd),
    .tags       (tag_q),
    .hit        (hit_b),
    .sel        (sel_b),
    .load_hazard(lh_b)
  );

  assign fwd_a_sel   = hit_a ? sel_a : SW'(FWD_REGFILE);
  assign fwd_b_sel   = hit_b ? sel_b : SW'(FWD_REGFILE);
  assign hazard      = id_valid && (lh_a || lh_b);
  assign freeze_back = tag_q[LOAD_STAGE].valid && tag_q[LOAD_STAGE].load && !mem_ready;
  assign hold_front  = hazard || freeze_back;
  assign bubble_exe  = hazard && !freeze_back;
  assign stall_cnt   = stall_cnt_q;

  // A freeze holds every tag and swallows any flush; upstream re-presents the flush.
  always_comb begin
    tag_d = tag_q;
    if (!freeze_back) begin
      for (int k = DEPTH; k >= 2; k--) begin
        tag_d[k] = tag_q[k-1];
      end
      if (hazard || flush) begin
        tag_d[1] = '0;
      end else begin
        tag_d[1].valid = id_valid;
        tag_d[1].rd    = TagRdW'(id_rd);
        tag_d[1].wreg  = id_wreg;
        tag_d[1].load  = id_m2reg;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hold_front && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      tag_q       <= tag_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed scenarios plus random traffic against an
// instruction-level model, on a default instance and a deep/zero-reg/narrow-counter one.
module tb_pipe_hazard_unit;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic          id_rs1_rd = 1'b0, id_rs2_rd = 1'b0, id_wreg = 1'b0, id_m2reg = 1'b0;
  logic          flush = 1'b0, mem_ready = 1'b1;

  logic [1:0]  a_sel_a, a_sel_b;
  logic        a_hold, a_bub, a_frz;
  logic [15:0] a_cnt;
  logic [2:0]  b_sel_a, b_sel_b;
  logic        b_hold, b_bub, b_frz;
  logic [2:0]  b_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit #(
    .REG_AW(AW), .DEPTH(2), .LOAD_STAGE(2), .ZERO_REG(0), .CNT_W(16)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_rd(id_rs1_rd), .id_rs2_rd(id_rs2_rd), .id_rd(id_rd), .id_wreg(id_wreg),
    .id_m2reg(id_m2reg), .flush(flush), .mem_ready(mem_ready), .fwd_a_sel(a_sel_a),
    .fwd_b_sel(a_sel_b), .hold_front(a_hold), .bubble_exe(a_bub), .freeze_back(a_frz),
    .stall_cnt(a_cnt)
  );

  pipe_hazard_unit #(
    .REG_AW(AW), .DEPTH(4), .LOAD_STAGE(3), .ZERO_REG(1), .CNT_W(3)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_rd(id_rs1_rd), .id_rs2_rd(id_rs2_rd), .id_rd(id_rd), .id_wreg(id_wreg),
    .id_m2reg(id_m2reg), .flush(flush), .mem_ready(mem_ready), .fwd_a_sel(b_sel_a),
    .fwd_b_sel(b_sel_b), .hold_front(b_hold), .bubble_exe(b_bub), .freeze_back(b_frz),
    .stall_cnt(b_cnt)
  );

  // Model: each slot is the instruction occupying that stage after ID.
  typedef struct {
    bit v;
    int rd;
    bit w;
    bit ld;
  } mtag_t;

  mtag_t mp[2][1:4];
  int    m_cnt[2];
  int    dep[2]  = '{2, 4};
  int    ls[2]   = '{2, 3};
  int    zr[2]   = '{0, 1};
  int    cmax[2] = '{65535, 7};

  function automatic int m_sel(int u, int rs, bit en);
    if (!en || (zr[u] != 0 && rs == 0)) return 0;
    for (int k = 1; k <= dep[u]; k++) begin
      if (mp[u][k].v && mp[u][k].w && mp[u][k].rd == rs) return k;
    end
    return 0;
  endfunction

  function automatic bit m_op_stall(int u, int rs, bit en);
    int k = m_sel(u, rs, en);
    return (k != 0) && mp[u][k].ld && (k < ls[u]);
  endfunction

  function automatic bit m_freeze(int u);
    return mp[u][ls[u]].v && mp[u][ls[u]].ld && !mem_ready;
  endfunction

  function automatic bit m_hazard(int u);
    return id_valid && (m_op_stall(u, int'(id_rs1), id_rs1_rd) ||
                        m_op_stall(u, int'(id_rs2), id_rs2_rd));
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_cnt[u] = 0;
      for (int k = 1; k <= 4; k++) mp[u][k] = '{v: 1'b0, rd: 0, w: 1'b0, ld: 1'b0};
    end
  endtask

  task automatic model_step(int u);
    bit fz = m_freeze(u);
    bit hz = m_hazard(u);
    if ((fz || hz) && m_cnt[u] < cmax[u]) m_cnt[u]++;
    if (!fz) begin
      for (int k = dep[u]; k >= 2; k--) mp[u][k] = mp[u][k-1];
      if (hz || flush) mp[u][1] = '{v: 1'b0, rd: 0, w: 1'b0, ld: 1'b0};
      else mp[u][1] = '{v: id_valid, rd: int'(id_rd), w: id_wreg, ld: id_m2reg};
    end
  endtask

  task automatic set_idle();
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rs1_rd = 1'b0; id_rs2_rd = 1'b0; id_wreg = 1'b0; id_m2reg = 1'b0;
    flush = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Present one ID instruction for a cycle; negative register means "not used".
  task automatic drive(input int rs1, input int rs2, input int rd, input bit ld,
                       input bit fl, input bit mr);
    @(posedge clk); #1;
    id_valid  = 1'b1;
    id_rs1_rd = (rs1 >= 0); id_rs1 = (rs1 >= 0) ? AW'(rs1) : '0;
    id_rs2_rd = (rs2 >= 0); id_rs2 = (rs2 >= 0) ? AW'(rs2) : '0;
    id_wreg   = (rd >= 0);  id_rd  = (rd >= 0) ? AW'(rd) : '0;
    id_m2reg  = ld; flush = fl; mem_ready = mr;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    drive(5, 5, 6, 0, 0, 1);
    checks++; if ({a_sel_a, a_sel_b, a_hold, a_bub, a_frz, a_cnt} !== '0) begin
      errors++; $display("FAIL reset_idle_a: got %h want 0", {a_sel_a, a_sel_b, a_hold, a_frz});
    end
    do_reset();
    drive(-1, -1, 5, 1, 0, 1);
    drive(5, 5, 6, 0, 0, 1);
    checks++; if (a_hold !== 1'b1) begin
      errors++; $display("FAIL reset_prestall: got %0b want 1", a_hold);
    end
    drive(5, 5, 6, 0, 0, 0);
    checks++; if (a_frz !== 1'b1 || a_cnt !== 16'd1) begin
      errors++; $display("FAIL reset_prefreeze: got frz=%0b cnt=%0d want 1/1", a_frz, a_cnt);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({a_sel_a, a_sel_b, a_hold, a_bub, a_frz, a_cnt} !== '0) begin
      errors++; $display("FAIL reset_async_a: got sel=%0d/%0d h=%0b b=%0b f=%0b cnt=%0d want 0",
                         a_sel_a, a_sel_b, a_hold, a_bub, a_frz, a_cnt);
    end
    checks++; if ({b_sel_a, b_sel_b, b_hold, b_bub, b_frz, b_cnt} !== '0) begin
      errors++; $display("FAIL reset_async_b: got h=%0b cnt=%0d want 0", b_hold, b_cnt);
    end
    set_idle();
    @(negedge clk) rst_n = 1'b1;
    drive(-1, -1, 3, 0, 0, 1);
    drive(3, -1, 7, 0, 0, 1);
    checks++; if (a_sel_a !== 2'd1) begin
      errors++; $display("FAIL reset_then_fwd: got %0d want 1", a_sel_a);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(-1, -1, 5, 1, 0, 1);
    drive(5, 5, 6, 0, 0, 1);
    checks++; if (a_hold !== 1'b1 || a_bub !== 1'b1 || a_frz !== 1'b0) begin
      errors++; $display("FAIL load_use_stall: got h=%0b b=%0b f=%0b want 1/1/0",
                         a_hold, a_bub, a_frz);
    end
    drive(5, 5, 6, 0, 0, 1);
    checks++; if (a_hold !== 1'b0 || a_sel_a !== 2'd2 || a_sel_b !== 2'd2) begin
      errors++; $display("FAIL load_use_fwd: got h=%0b sel=%0d/%0d want 0/2/2",
                         a_hold, a_sel_a, a_sel_b);
    end
    checks++; if (a_cnt !== 16'd1) begin
      errors++; $display("FAIL load_use_cnt: got %0d want 1", a_cnt);
    end
  endtask

  task automatic test_youngest();
    do_reset();
    drive(-1, -1, 7, 0, 0, 1);
    drive(-1, -1, 7, 0, 0, 1);
    drive(7, 7, 8, 0, 0, 1);
    checks++; if (a_sel_a !== 2'd1 || a_sel_b !== 2'd1 || a_hold !== 1'b0) begin
      errors++; $display("FAIL youngest: got sel=%0d/%0d h=%0b want 1/1/0",
                         a_sel_a, a_sel_b, a_hold);
    end
  endtask

  task automatic test_mem_freeze();
    do_reset();
    drive(-1, -1, 9, 1, 0, 1);
    drive(1, 2, 11, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(9, -1, 10, 0, 0, 0);
      checks++; if (a_frz !== 1'b1 || a_hold !== 1'b1 || a_bub !== 1'b0 || a_sel_a !== 2'd2)
      begin
        errors++; $display("FAIL freeze_%0d: got f=%0b h=%0b b=%0b sel=%0d want 1/1/0/2",
                           i, a_frz, a_hold, a_bub, a_sel_a);
      end
    end
    drive(9, -1, 10, 0, 0, 1);
    checks++; if (a_frz !== 1'b0 || a_hold !== 1'b0 || a_sel_a !== 2'd2 || a_cnt !== 16'd3)
    begin
      errors++; $display("FAIL freeze_release: got f=%0b h=%0b sel=%0d cnt=%0d want 0/0/2/3",
                         a_frz, a_hold, a_sel_a, a_cnt);
    end
    drive(10, 11, 12, 0, 0, 1);
    checks++; if (a_sel_a !== 2'd1 || a_sel_b !== 2'd2) begin
      errors++; $display("FAIL freeze_after: got sel=%0d/%0d want 1/2", a_sel_a, a_sel_b);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(-1, -1, 5, 1, 0, 1);
    drive(5, -1, 6, 0, 1, 1);
    checks++; if (a_hold !== 1'b1 || a_bub !== 1'b1) begin
      errors++; $display("FAIL flush_hazard: got h=%0b b=%0b want 1/1", a_hold, a_bub);
    end
    drive(5, -1, 8, 0, 0, 1);
    checks++; if (a_sel_a !== 2'd2 || a_hold !== 1'b0) begin
      errors++; $display("FAIL flush_single_bubble: got sel=%0d h=%0b want 2/0", a_sel_a, a_hold);
    end
    drive(8, 5, 9, 0, 0, 1);
    checks++; if (a_sel_a !== 2'd1 || a_sel_b !== 2'd0) begin
      errors++; $display("FAIL flush_advance: got sel=%0d/%0d want 1/0", a_sel_a, a_sel_b);
    end
    drive(-1, -1, 11, 0, 1, 1);
    drive(11, -1, 12, 0, 0, 1);
    checks++; if (a_sel_a !== 2'd0) begin
      errors++; $display("FAIL flush_squash: got %0d want 0", a_sel_a);
    end
  endtask

  task automatic test_deep_zero();
    do_reset();
    drive(-1, -1, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 1);
    checks++; if (b_sel_a !== 3'd0 || b_sel_b !== 3'd0 || b_hold !== 1'b0) begin
      errors++; $display("FAIL zero_reg_b: got sel=%0d/%0d h=%0b want 0/0/0",
                         b_sel_a, b_sel_b, b_hold);
    end
    checks++; if (a_sel_a !== 2'd1) begin
      errors++; $display("FAIL zero_reg_a: got %0d want 1", a_sel_a);
    end
    drive(-1, -1, 12, 1, 0, 1);
    for (int i = 0; i < 2; i++) begin
      drive(12, -1, 13, 0, 0, 1);
      checks++; if (b_hold !== 1'b1 || b_bub !== 1'b1) begin
        errors++; $display("FAIL deep_stall_%0d: got h=%0b b=%0b want 1/1", i, b_hold, b_bub);
      end
    end
    drive(12, -1, 13, 0, 0, 1);
    checks++; if (b_hold !== 1'b0 || b_sel_a !== 3'd3 || b_cnt !== 3'd2) begin
      errors++; $display("FAIL deep_fwd: got h=%0b sel=%0d cnt=%0d want 0/3/2",
                         b_hold, b_sel_a, b_cnt);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    drive(-1, -1, 1, 1, 0, 1);
    for (int i = 0; i < 12; i++) drive(1, -1, 2, 0, 0, 0);
    drive(1, -1, 2, 0, 0, 1);
    checks++; if (a_cnt !== 16'd12) begin
      errors++; $display("FAIL sat_count_a: got %0d want 12", a_cnt);
    end
    checks++; if (b_cnt !== 3'd7) begin
      errors++; $display("FAIL sat_count_b: got %0d want 7", b_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      id_valid  = ($urandom_range(0, 7) != 0);
      id_rs1    = AW'($urandom_range(0, 3));
      id_rs2    = AW'($urandom_range(0, 3));
      id_rs1_rd = ($urandom_range(0, 4) != 0);
      id_rs2_rd = ($urandom_range(0, 2) != 0);
      id_rd     = AW'($urandom_range(0, 3));
      id_wreg   = ($urandom_range(0, 4) != 0);
      id_m2reg  = ($urandom_range(0, 2) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        int e_sa, e_sb, g_sa, g_sb, g_cnt;
        bit e_fz, e_hz, g_h, g_b, g_f;
        e_sa  = m_sel(u, int'(id_rs1), id_rs1_rd);
        e_sb  = m_sel(u, int'(id_rs2), id_rs2_rd);
        e_fz  = m_freeze(u);
        e_hz  = m_hazard(u);
        g_sa  = (u == 0) ? int'(a_sel_a) : int'(b_sel_a);
        g_sb  = (u == 0) ? int'(a_sel_b) : int'(b_sel_b);
        g_h   = (u == 0) ? a_hold : b_hold;
        g_b   = (u == 0) ? a_bub : b_bub;
        g_f   = (u == 0) ? a_frz : b_frz;
        g_cnt = (u == 0) ? int'(a_cnt) : int'(b_cnt);
        checks++; if (g_sa !== e_sa) begin
          errors++; $display("FAIL rnd%0d_sel_a @%0d: got %0d want %0d", u, i, g_sa, e_sa);
        end
        checks++; if (g_sb !== e_sb) begin
          errors++; $display("FAIL rnd%0d_sel_b @%0d: got %0d want %0d", u, i, g_sb, e_sb);
        end
        checks++; if (g_f !== e_fz) begin
          errors++; $display("FAIL rnd%0d_freeze @%0d: got %0b want %0b", u, i, g_f, e_fz);
        end
        checks++; if (g_h !== (e_hz | e_fz)) begin
          errors++; $display("FAIL rnd%0d_hold @%0d: got %0b want %0b", u, i, g_h, e_hz | e_fz);
        end
        checks++; if (g_b !== (e_hz & !e_fz)) begin
          errors++; $display("FAIL rnd%0d_bubble @%0d: got %0b want %0b", u, i, g_b,
                             e_hz & !e_fz);
        end
        checks++; if (g_cnt !== m_cnt[u]) begin
          errors++; $display("FAIL rnd%0d_cnt @%0d: got %0d want %0d", u, i, g_cnt, m_cnt[u]);
        end
      end
      model_step(0);
      model_step(1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_use();
    test_youngest();
    test_mem_freeze();
    test_flush();
    test_deep_zero();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
